video_char_queue: RTL and testbench
===================================

VIDEO_CHAR_QUEUE -- requirements
Module: video_char_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entry count (power of two, >=2).
REQ-002 SHALL have parameter SCREEN_CELLS, default 1200, number of addressable text cells (40x30).
REQ-003 SHALL have port wire_clock, input, 1, sole clock; all logic on its rising edge.
REQ-004 SHALL have port wire_reset, input, 1, reset: synchronous, active-low.
REQ-005 SHALL have port videoflag, input, 1, CPU outchar strobe; high for one or more cycles per character.
REQ-006 SHALL have port bus_vga_pos, input, 16, cell index of the character to write.
REQ-007 SHALL have port bus_vga_char, input, 16, character word (bits 7:0 code, bits 15:8 attribute), passed through unmodified.
REQ-008 SHALL have port vram_req, output, 1, request for the video-RAM write port.
REQ-009 SHALL have port vram_grant, input, 1, arbiter grant; meaningful only while vram_req is high.
REQ-010 SHALL have port vram_we, output, 1, one-cycle video-RAM write enable.
REQ-011 SHALL have port vram_addr, output, 11, video-RAM cell address.
REQ-012 SHALL have port vram_data, output, 16, video-RAM write data.
REQ-013 SHALL have port fifo_full, output, 1, queue holds DEPTH entries.
REQ-014 SHALL have port overflow, output, 1, sticky: a character was lost because the queue was full.
REQ-015 SHALL have port bad_pos, output, 1, sticky: a character was discarded for an out-of-range position.

Function
REQ-016 SHALL register videoflag each cycle and detect a capture event when videoflag=1 and the previous sample=0; a held-high strobe produces exactly one event.
REQ-017 SHALL, on a capture event, sample bus_vga_pos and bus_vga_char on that same edge.
REQ-018 SHALL discard a captured entry with bus_vga_pos >= SCREEN_CELLS and set bad_pos; the queue is unchanged.
REQ-019 SHALL push a valid entry {pos[10:0], char} into the queue; the entry is visible (count incremented) the following cycle.
REQ-020 SHALL, on a valid capture while full with no pop on that edge, drop the entry and set overflow.
REQ-021 SHALL, when a push and a pop coincide while full, accept the push; the count is unchanged.
REQ-022 SHALL, when a push and a pop coincide while empty, not pop; the entry is pushed normally.
REQ-023 SHALL implement drain FSM states IDLE, REQ and WRITE.
REQ-024 SHALL, in IDLE with the queue non-empty, go to REQ and register vram_req=1.
REQ-025 SHALL, in REQ, hold vram_req=1 until vram_grant=1 is sampled, then go to WRITE.
REQ-026 SHALL, on entry to WRITE, drive vram_we=1 for exactly one cycle with vram_addr and vram_data from the head entry, pop the head, drop vram_req, and return to IDLE.
REQ-027 SHALL hold vram_we=0 at all times outside WRITE; vram_addr and vram_data hold their last values.
REQ-028 SHALL give minimum latency from capture edge to vram_we high of 3 cycles with vram_grant tied high; back-to-back entries SHALL drain at one per 3 cycles.
REQ-029 SHALL wrap read and write pointers modulo DEPTH, using a count of log2(DEPTH)+1 bits.
REQ-030 SHALL drive fifo_full combinationally from count==DEPTH.

Reset
REQ-031 SHALL, while wire_reset=0 at a rising edge, force state=IDLE, empty the queue, clear pointers, the videoflag sample, overflow and bad_pos, and drive vram_req=0, vram_we=0, vram_addr=0, vram_data=0.
REQ-032 SHALL abandon any in-flight REQ or WRITE on reset; no write completes on or after the reset edge.
REQ-033 SHALL allow overflow and bad_pos to be cleared only by reset.

Structure
REQ-034 SHALL place SCREEN_CELLS default, the address width (11) and the drain-state enumeration in the shared video package.
REQ-035 SHALL implement the queue as sub-module char_fifo (push, pop, full, empty, head data); capture and drain logic SHALL be in video_char_queue.

Verification
REQ-036 SHALL cover single write: videoflag pulse, pos=0x0205, char=0x0041, grant tied 1 -> vram_we high once, 3 cycles later, addr=0x205, data=0x0041.
REQ-037 SHALL cover held strobe: videoflag high for 5 cycles -> exactly one vram_we.
REQ-038 SHALL cover bad position: pos=1200 -> no vram_we, bad_pos=1, queue stays empty.
REQ-039 SHALL cover overflow: grant=0, 9 strobes with chars 1..9 -> fifo_full after the 8th strobe and overflow=1 after the 9th; with grant=1, chars 1..8 written in order and char 9 absent.
REQ-040 SHALL cover grant stall: grant=0 for 10 cycles after the request -> vram_req held 10 cycles, then vram_we one cycle after grant is seen.
REQ-041 SHALL cover mid-operation reset: wire_reset=0 in REQ with 3 entries queued -> next cycle vram_req=0, empty, and no vram_we after reset is released.

Source files
------------

// File: rtl/video_char_queue_pkg.sv
// video_char_queue_pkg: shared video constants and the drain-state encoding
package video_char_queue_pkg;
  localparam int SCREEN_CELLS_DEF = 1200;
  localparam int ADDR_W = 11;
  localparam int CHAR_W = 16;
  localparam int ENTRY_W = ADDR_W + CHAR_W;
  typedef enum logic [1:0] {IDLE, REQ, WRITE} drain_state_t;
endpackage

// File: rtl/video_char_queue_char_fifo.sv
// char_fifo: power-of-two circular queue with combinational head and full/empty flags
module char_fifo #(
  parameter int DEPTH = 8,
  parameter int W = 27
) (
  input  logic         wire_clock,
  input  logic         wire_reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0] count;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign head = mem[rptr];
  // a pop on an empty queue is ignored; a push into a full queue needs a simultaneous pop
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  always_ff @(posedge wire_clock)
    if (do_push) mem[wptr] <= din;
  always_ff @(posedge wire_clock) begin
    if (!wire_reset) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop) rptr <= rptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/video_char_queue.sv
// video_char_queue: captures CPU character strobes into a queue and drains them to video RAM
module video_char_queue
  import video_char_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int SCREEN_CELLS = SCREEN_CELLS_DEF
) (
  input  logic              wire_clock,
  input  logic              wire_reset,
  input  logic              videoflag,
  input  logic [15:0]       bus_vga_pos,
  input  logic [CHAR_W-1:0] bus_vga_char,
  output logic              vram_req,
  input  logic              vram_grant,
  output logic              vram_we,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [CHAR_W-1:0] vram_data,
  output logic              fifo_full,
  output logic              overflow,
  output logic              bad_pos
);
  drain_state_t state, next;
  logic flag_q, capture, pos_ok, push, pop, empty;
  logic [ENTRY_W-1:0] head;
  assign capture = videoflag & ~flag_q;
  assign pos_ok = 32'(bus_vga_pos) < SCREEN_CELLS;
  assign pop = state == WRITE;
  assign push = capture & pos_ok;
  char_fifo #(.DEPTH(DEPTH), .W(ENTRY_W)) u_fifo (
    .wire_clock(wire_clock),
    .wire_reset(wire_reset),
    .push(push),
    .pop(pop),
    .din({bus_vga_pos[ADDR_W-1:0], bus_vga_char}),
    .full(fifo_full),
    .empty(empty),
    .head(head)
  );
  always_comb begin
    next = state;
    next = (state == IDLE && !empty) ? REQ :
           (state == REQ && vram_grant) ? WRITE :
           (state == WRITE) ? IDLE : state;
  end
  always_ff @(posedge wire_clock) begin
    if (!wire_reset) begin
      state <= IDLE;
      flag_q <= 1'b0;
      vram_req <= 1'b0;
      vram_we <= 1'b0;
      vram_addr <= '0;
      vram_data <= '0;
      overflow <= 1'b0;
      bad_pos <= 1'b0;
    end else begin
      state <= next;
      flag_q <= videoflag;
      vram_req <= next != IDLE;
      vram_we <= pop;
      if (pop) {vram_addr, vram_data} <= head;
      if (capture && !pos_ok) bad_pos <= 1'b1;
      // the queue accepts a push while full only when the head leaves on the same edge
      if (push && fifo_full && !pop) overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_video_char_queue.sv
// tb_video_char_queue: directed checks of capture, drain timing, overflow and reset
module tb_video_char_queue;
  logic wire_clock = 1'b0;
  logic wire_reset = 1'b0;
  logic videoflag = 1'b0;
  logic [15:0] bus_vga_pos = '0;
  logic [15:0] bus_vga_char = '0;
  logic vram_grant = 1'b1;
  logic vram_req, vram_we, fifo_full, overflow, bad_pos;
  logic [10:0] vram_addr;
  logic [15:0] vram_data;
  int vectors = 0;
  int miscompares = 0;
  int we_cnt = 0;
  logic [26:0] wq [$];

  video_char_queue #(.DEPTH(8), .SCREEN_CELLS(1200)) dut (
    .wire_clock(wire_clock),
    .wire_reset(wire_reset),
    .videoflag(videoflag),
    .bus_vga_pos(bus_vga_pos),
    .bus_vga_char(bus_vga_char),
    .vram_req(vram_req),
    .vram_grant(vram_grant),
    .vram_we(vram_we),
    .vram_addr(vram_addr),
    .vram_data(vram_data),
    .fifo_full(fifo_full),
    .overflow(overflow),
    .bad_pos(bad_pos)
  );

  always #5 wire_clock = ~wire_clock;

  always @(posedge wire_clock)
    if (vram_we) begin
      we_cnt++;
      wq.push_back({vram_addr, vram_data});
    end

  task automatic tick();
    @(posedge wire_clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic strobe(input logic [15:0] pos, input logic [15:0] ch);
    videoflag = 1'b1;
    bus_vga_pos = pos;
    bus_vga_char = ch;
    tick();
    videoflag = 1'b0;
    tick();
  endtask

  function automatic logic [26:0] wq_at(input int i);
    return (wq.size() > i) ? wq[i] : '1;
  endfunction

  initial begin
    tick();
    tick();
    check("rst_req", 32'(vram_req), 0);
    check("rst_we", 32'(vram_we), 0);
    check("rst_addr", 32'(vram_addr), 0);
    check("rst_data", 32'(vram_data), 0);
    check("rst_full", 32'(fifo_full), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_bad", 32'(bad_pos), 0);
    wire_reset = 1'b1;
    tick();
    // single write: capture edge then vram_we three edges later
    we_cnt = 0;
    wq.delete();
    videoflag = 1'b1;
    bus_vga_pos = 16'h0205;
    bus_vga_char = 16'h0041;
    tick();
    videoflag = 1'b0;
    check("sw_we_c0", 32'(vram_we), 0);
    tick();
    check("sw_req_c1", 32'(vram_req), 1);
    check("sw_we_c1", 32'(vram_we), 0);
    tick();
    check("sw_we_c2", 32'(vram_we), 0);
    tick();
    check("sw_we_c3", 32'(vram_we), 1);
    check("sw_addr", 32'(vram_addr), 32'h205);
    check("sw_data", 32'(vram_data), 32'h0041);
    check("sw_req_c3", 32'(vram_req), 0);
    tick();
    check("sw_we_c4", 32'(vram_we), 0);
    repeat (4) tick();
    check("sw_count", 32'(we_cnt), 1);
    // held strobe yields one write
    we_cnt = 0;
    wq.delete();
    videoflag = 1'b1;
    bus_vga_pos = 16'h0010;
    bus_vga_char = 16'h1234;
    repeat (5) tick();
    videoflag = 1'b0;
    repeat (8) tick();
    check("hold_count", 32'(we_cnt), 1);
    check("hold_entry", 32'(wq_at(0)), {5'd0, 11'h010, 16'h1234});
    // out-of-range position is discarded
    we_cnt = 0;
    strobe(16'd1200, 16'h00AA);
    check("bad_flag", 32'(bad_pos), 1);
    repeat (5) tick();
    check("bad_count", 32'(we_cnt), 0);
    check("bad_req", 32'(vram_req), 0);
    // last valid cell
    wq.delete();
    strobe(16'd1199, 16'h0042);
    repeat (5) tick();
    check("edge_entry", 32'(wq_at(0)), {5'd0, 11'h4AF, 16'h0042});
    // overflow with grant held low
    vram_grant = 1'b0;
    for (int i = 1; i <= 7; i++) strobe(16'(i), 16'(i));
    check("ovf_full7", 32'(fifo_full), 0);
    strobe(16'd8, 16'd8);
    check("ovf_full8", 32'(fifo_full), 1);
    check("ovf_flag8", 32'(overflow), 0);
    strobe(16'd9, 16'd9);
    check("ovf_flag9", 32'(overflow), 1);
    check("ovf_full9", 32'(fifo_full), 1);
    wq.delete();
    vram_grant = 1'b1;
    repeat (30) tick();
    check("ovf_drained", 32'(wq.size()), 8);
    for (int i = 0; i < 8; i++)
      check($sformatf("ovf_entry%0d", i + 1), 32'(wq_at(i)), {5'd0, 11'(i + 1), 16'(i + 1)});
    check("ovf_full_after", 32'(fifo_full), 0);
    check("ovf_sticky", 32'(overflow), 1);
    check("bad_sticky", 32'(bad_pos), 1);
    // grant stall: request held while grant is low
    vram_grant = 1'b0;
    wq.delete();
    videoflag = 1'b1;
    bus_vga_pos = 16'h0020;
    bus_vga_char = 16'h0055;
    tick();
    videoflag = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("stall_req%0d", i), 32'(vram_req), 1);
      check($sformatf("stall_we%0d", i), 32'(vram_we), 0);
    end
    vram_grant = 1'b1;
    tick();
    check("stall_we_g0", 32'(vram_we), 0);
    tick();
    check("stall_we_g1", 32'(vram_we), 1);
    check("stall_data", 32'(vram_data), 32'h0055);
    check("stall_addr", 32'(vram_addr), 32'h020);
    repeat (3) tick();
    // reset while requesting with three entries queued
    vram_grant = 1'b0;
    for (int i = 0; i < 3; i++) strobe(16'(i + 100), 16'(i + 16'h0300));
    check("mr_req_pre", 32'(vram_req), 1);
    wire_reset = 1'b0;
    tick();
    check("mr_req", 32'(vram_req), 0);
    check("mr_addr", 32'(vram_addr), 0);
    check("mr_data", 32'(vram_data), 0);
    check("mr_ovf", 32'(overflow), 0);
    check("mr_bad", 32'(bad_pos), 0);
    wire_reset = 1'b1;
    vram_grant = 1'b1;
    we_cnt = 0;
    repeat (10) tick();
    check("mr_count", 32'(we_cnt), 0);
    check("mr_req_post", 32'(vram_req), 0);
    check("mr_full", 32'(fifo_full), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
